// File: rtl/iir_sos_mac_sequencer_pkg.sv
// Shared constants for the biquad-cascade MAC sequencer: FSM encodings,
// operand slot order within one section pass, and coefficients per section.
package iir_sos_mac_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_MAC    = 3'd1;
    localparam state_t ST_WAIT   = 3'd2;
    localparam state_t ST_UPDATE = 3'd3;
    localparam state_t ST_OUT    = 3'd4;

    localparam int COEFS_PER_SEC = 5;

    // Slot k of a section pass; the ROM holds b0,b1,b2,a1,a2 in the same order.
    localparam int OP_X0 = 0;
    localparam int OP_X1 = 1;
    localparam int OP_X2 = 2;
    localparam int OP_Y1 = 3;
    localparam int OP_Y2 = 4;

endpackage

// File: rtl/iir_sos_mac_sequencer_if.sv
// Bus between the sequencer and the shared external MAC / coefficient ROM.
// Handshake: none; the MAC consumes coef_addr/mac_operand on every cycle mac_en=1.
interface iir_sos_mac_sequencer_if #(
    parameter int NUM_SECTIONS = 4,
    parameter int INOUT_WIDTH  = 16,
    parameter int ACC_WIDTH    = 48
);
    localparam int CAW = $clog2(5 * NUM_SECTIONS);

    logic [CAW-1:0]                coef_addr;
    logic signed [INOUT_WIDTH-1:0] mac_operand;
    logic                          mac_en;
    logic                          mac_clr;
    logic                          mac_sub;
    logic signed [ACC_WIDTH-1:0]   mac_acc;

    modport master (
        output coef_addr, mac_operand, mac_en, mac_clr, mac_sub,
        input  mac_acc
    );

    modport slave (
        input  coef_addr, mac_operand, mac_en, mac_clr, mac_sub,
        output mac_acc
    );

endinterface

// File: rtl/iir_sos_history.sv
// Per-section DF1 history (x[n-1], x[n-2], y[n-1], y[n-2]) with a one-section
// shift port and a whole-file clear.
module iir_sos_history #(
    parameter int NUM_SECTIONS = 4,
    parameter int W            = 16,
    parameter int SW           = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                shift_i,
    input  logic [SW-1:0]       sec_i,
    input  logic signed [W-1:0] x_new_i,
    input  logic signed [W-1:0] y_new_i,
    output logic signed [W-1:0] x1_o,
    output logic signed [W-1:0] x2_o,
    output logic signed [W-1:0] y1_o,
    output logic signed [W-1:0] y2_o
);

    logic signed [W-1:0] x1_q [NUM_SECTIONS];
    logic signed [W-1:0] x2_q [NUM_SECTIONS];
    logic signed [W-1:0] y1_q [NUM_SECTIONS];
    logic signed [W-1:0] y2_q [NUM_SECTIONS];

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int s = 0; s < NUM_SECTIONS; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
        end else if (shift_i) begin
            x2_q[sec_i] <= x1_q[sec_i];
            x1_q[sec_i] <= x_new_i;
            y2_q[sec_i] <= y1_q[sec_i];
            y1_q[sec_i] <= y_new_i;
        end
    end

    assign x1_o = x1_q[sec_i];
    assign x2_o = x2_q[sec_i];
    assign y1_o = y1_q[sec_i];
    assign y2_o = y2_q[sec_i];

endmodule

// File: rtl/iir_sos_mac_sequencer.sv
// Cascaded DF1 biquad sequencer driving one shared external MAC per sample.
// Define IIR_SEQ_SAT_EN to saturate each section result; otherwise it wraps.
module iir_sos_mac_sequencer
    import iir_sos_mac_sequencer_pkg::*;
#(
    parameter int NUM_SECTIONS = 4,
    parameter int INOUT_WIDTH  = 16,
    parameter int SCALE_FACTOR = 23,
    parameter int ACC_WIDTH    = 48,
    parameter int MAC_LATENCY  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic signed [INOUT_WIDTH-1:0] s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic signed [INOUT_WIDTH-1:0] m_axis_tdata,
    iir_sos_mac_sequencer_if.master       mac,
    input  logic                          flush,
    output logic                          busy,
    output state_t                        dbg_state_o
);

    localparam int W   = INOUT_WIDTH;
    localparam int AW1 = ACC_WIDTH + 1;
    localparam int SW  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
    localparam int CAW = $clog2(COEFS_PER_SEC * NUM_SECTIONS);
    localparam int CW  = ($clog2(MAC_LATENCY + 1) > 3) ? $clog2(MAC_LATENCY + 1) : 3;

    localparam logic [SW-1:0]         LAST_SEC  = SW'(NUM_SECTIONS - 1);
    localparam logic [CW-1:0]         MAC_LAST  = CW'(COEFS_PER_SEC - 1);
    localparam logic [CW-1:0]         WAIT_LAST = CW'(MAC_LATENCY - 1);
    localparam logic signed [AW1-1:0] RND_C     = AW1'(1) <<< (SCALE_FACTOR - 1);

    state_t              state_q, state_d;
    logic [SW-1:0]       sec_q, sec_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic signed [W-1:0] x_cur_q, x_cur_d;
    logic signed [W-1:0] out_q, out_d;
    logic                flush_pend_q, flush_pend_d;

    logic                hist_shift;
    logic                hist_flush;
    logic                in_mac;
    logic signed [W-1:0] h_x1, h_x2, h_y1, h_y2;
    logic signed [W-1:0] operand;
    logic signed [W-1:0] y_sec;

    // Round-half-up then drop the fractional bits; one guard bit keeps the add exact.
    logic signed [AW1-1:0] rnd_full, y_shift;
    assign rnd_full = {mac.mac_acc[ACC_WIDTH-1], mac.mac_acc} + RND_C;
    assign y_shift  = rnd_full >>> SCALE_FACTOR;

`ifdef IIR_SEQ_SAT_EN
    logic ovf;
    assign ovf   = !((&y_shift[AW1-1:W-1]) || !(|y_shift[AW1-1:W-1]));
    assign y_sec = ovf ? (y_shift[AW1-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                       : y_shift[W-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^y_shift[AW1-1:W];
    assign y_sec     = y_shift[W-1:0];
`endif

    // A pending flush is applied only once the sample in flight has drained.
    assign hist_flush = (state_q == ST_IDLE) && (flush || flush_pend_q);

    always_comb begin
        state_d      = state_q;
        sec_d        = sec_q;
        cnt_d        = cnt_q;
        x_cur_d      = x_cur_q;
        out_d        = out_q;
        flush_pend_d = flush_pend_q;
        hist_shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                flush_pend_d = 1'b0;
                if (s_axis_tvalid) begin
                    x_cur_d = s_axis_tdata;
                    sec_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (cnt_q == MAC_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_UPDATE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_UPDATE: begin
                hist_shift = 1'b1;
                x_cur_d    = y_sec;
                if (sec_q == LAST_SEC) begin
                    out_d   = y_sec;
                    state_d = ST_OUT;
                end else begin
                    sec_d   = sec_q + 1'b1;
                    state_d = ST_MAC;
                end
            end
            ST_OUT: begin
                if (m_axis_tready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush && (state_q != ST_IDLE)) flush_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sec_q        <= '0;
            cnt_q        <= '0;
            x_cur_q      <= '0;
            out_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_q        <= sec_d;
            cnt_q        <= cnt_d;
            x_cur_q      <= x_cur_d;
            out_q        <= out_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    iir_sos_history #(
        .NUM_SECTIONS (NUM_SECTIONS),
        .W            (W),
        .SW           (SW)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .flush_i (hist_flush),
        .shift_i (hist_shift),
        .sec_i   (sec_q),
        .x_new_i (x_cur_q),
        .y_new_i (y_sec),
        .x1_o    (h_x1),
        .x2_o    (h_x2),
        .y1_o    (h_y1),
        .y2_o    (h_y2)
    );

    assign in_mac = (state_q == ST_MAC);

    always_comb begin
        operand = '0;
        if (in_mac) begin
            case (int'(cnt_q))
                OP_X0:   operand = x_cur_q;
                OP_X1:   operand = h_x1;
                OP_X2:   operand = h_x2;
                OP_Y1:   operand = h_y1;
                OP_Y2:   operand = h_y2;
                default: operand = '0;
            endcase
        end
    end

    assign mac.mac_en      = in_mac;
    assign mac.mac_operand = operand;
    assign mac.mac_clr     = in_mac && (int'(cnt_q) == OP_X0);
    assign mac.mac_sub     = in_mac && ((int'(cnt_q) == OP_Y1) || (int'(cnt_q) == OP_Y2));
    assign mac.coef_addr   = in_mac ? CAW'(COEFS_PER_SEC * int'(sec_q) + int'(cnt_q)) : '0;

    assign s_axis_tready = (state_q == ST_IDLE);
    assign m_axis_tvalid = (state_q == ST_OUT);
    assign m_axis_tdata  = out_q;
    assign busy          = (state_q != ST_IDLE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_iir_sos_mac_sequencer.sv
// Directed bench for iir_sos_mac_sequencer with a behavioural MAC/ROM and a
// DF1 cascade reference model feeding an expected-output queue.
`timescale 1ns/1ps
module tb_iir_sos_mac_sequencer;
    import iir_sos_mac_sequencer_pkg::*;

    localparam int NS  = 4;
    localparam int W   = 16;
    localparam int AW  = 48;
    localparam int ML  = 2;
    localparam int LAT = NS * (6 + ML) + 1;
    localparam logic signed [AW-1:0] FORCED_ACC = 48'sd335544320000; // 40000 * 2^23

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                s_tvalid, s_tready, m_tvalid, m_tready, flush, busy;
    logic signed [W-1:0] s_tdata, m_tdata;
    state_t              dbg_state;

    iir_sos_mac_sequencer_if #(.NUM_SECTIONS(NS), .INOUT_WIDTH(W), .ACC_WIDTH(AW)) mac_if ();

    iir_sos_mac_sequencer #(
        .NUM_SECTIONS (NS),
        .INOUT_WIDTH  (W),
        .SCALE_FACTOR (23),
        .ACC_WIDTH    (AW),
        .MAC_LATENCY  (ML)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .mac           (mac_if),
        .flush         (flush),
        .busy          (busy),
        .dbg_state_o   (dbg_state)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- external MAC + coefficient ROM ----------------
    longint             cf [0:31];
    bit                 force_acc;
    logic signed [63:0] mac_prod;
    logic signed [AW-1:0] acc_r, acc_p;

    always_comb mac_prod = longint'(mac_if.mac_operand) * cf[mac_if.coef_addr];

    always @(posedge clk) begin
        if (mac_if.mac_en) begin
            if (mac_if.mac_clr) acc_r <= mac_if.mac_sub ? AW'(-mac_prod) : AW'(mac_prod);
            else                acc_r <= mac_if.mac_sub ? acc_r - AW'(mac_prod) : acc_r + AW'(mac_prod);
        end
        acc_p <= acc_r;
    end

    assign mac_if.mac_acc = force_acc ? FORCED_ACC : acc_p;

    // ---------------- MAC bus monitor ----------------
    typedef struct packed {
        logic [4:0]          addr;
        logic                clr;
        logic                sub;
        logic signed [15:0]  op;
    } beat_t;
    beat_t beat_log[$];
    bit    mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mac_if.mac_en) begin
                beat_log.push_back({mac_if.coef_addr, mac_if.mac_clr, mac_if.mac_sub, mac_if.mac_operand});
            end else begin
                check("idle_operand", mac_if.mac_operand, 0);
                check("idle_coef_addr", mac_if.coef_addr, 0);
            end
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic signed [W-1:0] exp_q[$];
    longint mx1 [NS], mx2 [NS], my1 [NS], my2 [NS];

    function automatic logic signed [W-1:0] reduce(input longint acc);
        longint y;
        y = (acc + 64'sd4194304) >>> 23;
`ifdef IIR_SEQ_SAT_EN
        if (y > 32767)  return 16'sh7fff;
        if (y < -32768) return 16'sh8000;
`endif
        return y[15:0];
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endtask

    task automatic model_push(input logic signed [W-1:0] x);
        longint v, acc;
        logic signed [W-1:0] y;
        v = x;
        y = x;
        for (int s = 0; s < NS; s++) begin
            acc = cf[5*s] * v + cf[5*s+1] * mx1[s] + cf[5*s+2] * mx2[s]
                - cf[5*s+3] * my1[s] - cf[5*s+4] * my2[s];
            y = reduce(acc);
            mx2[s] = mx1[s]; mx1[s] = v;
            my2[s] = my1[s]; my1[s] = y;
            v = y;
        end
        exp_q.push_back(y);
    endtask

    task automatic set_coefs(input longint b0, input longint b1, input longint b2,
                             input longint a1, input longint a2);
        for (int i = 0; i < 32; i++) cf[i] = 0;
        for (int s = 0; s < NS; s++) begin
            cf[5*s] = b0; cf[5*s+1] = b1; cf[5*s+2] = b2; cf[5*s+3] = a1; cf[5*s+4] = a2;
        end
    endtask

    // ---------------- driver tasks ----------------
    // On return the accepting edge has passed: the current cycle is cycle 1.
    task automatic send(input logic signed [W-1:0] x, input bit with_flush, input bit push_exp);
        int n;
        if (with_flush) model_clear();
        if (push_exp) model_push(x);
        s_tdata  = x;
        s_tvalid = 1'b1;
        flush    = with_flush;
        n = 0;
        while (s_tready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("send_ready_wait", n < 200, 1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        flush    = 1'b0;
        s_tdata  = '0;
    endtask

    task automatic recv(input int hold, input int cyc0);
        int lat;
        logic signed [W-1:0] exp;
        lat = cyc0;
        while (m_tvalid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, LAT);
        if (m_tvalid !== 1'b1) return;
        check("scoreboard_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() == 0) return;
        exp = exp_q.pop_front();
        check("tdata", m_tdata, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_tdata", m_tdata, exp);
            check("hold_tvalid", m_tvalid, 1);
            check("hold_s_tready", s_tready, 0);
            check("hold_busy", busy, 1);
        end
        m_tready = 1'b1;
        @(posedge clk); #1;
        m_tready = 1'b0;
        check("after_out_s_tready", s_tready, 1);
        check("after_out_busy", busy, 0);
        check("after_out_tvalid", m_tvalid, 0);
    endtask

    task automatic hist_zero_check(input string tag);
        for (int s = 0; s < NS; s++) begin
            check({tag, "_x1"}, dut.u_hist.x1_q[s], 0);
            check({tag, "_x2"}, dut.u_hist.x2_q[s], 0);
            check({tag, "_y1"}, dut.u_hist.y1_q[s], 0);
            check({tag, "_y2"}, dut.u_hist.y2_q[s], 0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; flush = 1'b0;
        force_acc = 1'b0;
        set_coefs(0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_s_tready", s_tready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_mac_en", mac_if.mac_en, 0);
        check("rst_mac_clr", mac_if.mac_clr, 0);
        check("rst_mac_sub", mac_if.mac_sub, 0);
        check("rst_coef_addr", mac_if.coef_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, ST_IDLE);
        mon_en = 1'b1;

        // Pass-through filter: latency and MAC bus sequence
        set_coefs(64'sd8388608, 0, 0, 0, 0);
        beat_log.delete();
        send(16'sd1000, 1'b0, 1'b1);
        recv(0, 1);
        check("beat_count", beat_log.size(), 20);
        for (int i = 0; i < 20 && i < beat_log.size(); i++) begin
            check("beat_addr", beat_log[i].addr, i);
            check("beat_clr", beat_log[i].clr, (i % 5) == 0);
            check("beat_sub", beat_log[i].sub, (i % 5) >= 3);
            check("beat_operand", beat_log[i].op, ((i % 5) == 0) ? 1000 : 0);
        end

        // Output backpressure
        send(-16'sd1234, 1'b0, 1'b1);
        recv(10, 1);

        // Real filter, random samples; first one flushes in the handshake cycle
        set_coefs(64'sd4194304, 64'sd2097152, -64'sd1048576, -64'sd2097152, 64'sd524288);
        for (int i = 0; i < 6; i++) begin
            send(W'($urandom_range(0, 20000)) - 16'sd10000, i == 0, 1'b1);
            recv(0, 1);
        end

        // Section result overflow
        force_acc = 1'b1;
        send(16'sd7, 1'b0, 1'b0);
`ifdef IIR_SEQ_SAT_EN
        exp_q.push_back(16'sd32767);
`else
        exp_q.push_back(-16'sd25536);
`endif
        recv(0, 1);
        force_acc = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
        hist_zero_check("idle_flush");

        // Reset in the middle of a sample
        send(16'sd1000, 1'b0, 1'b0);
        repeat (11) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_s_tready", s_tready, 1);
        seen = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (m_tvalid === 1'b1) seen = 1'b1;
        end
        check("abort_no_output", seen, 0);
        model_clear();
        send(16'sd1000, 1'b0, 1'b1);
        recv(0, 1);
        for (int i = 0; i < 3; i++) begin
            send(16'sd0, 1'b0, 1'b1);
            recv(0, 1);
        end

        // Flush raised during MAC is deferred to the return to IDLE
        set_coefs(64'sd8388608, 0, 0, -64'sd4194304, 0);
        send(16'sd300, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("flush_in_mac_state", dbg_state, ST_MAC);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        recv(0, 4);
        @(posedge clk); #1;
        hist_zero_check("deferred_flush");
        model_clear();
        send(16'sd500, 1'b0, 1'b1);
        recv(0, 1);
        send(16'sd100, 1'b0, 1'b1);
        recv(0, 1);

        check("scoreboard_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
